sparse_flag_encoder: RTL and testbench

// - Write-side encoder for the flag-based sparse activation/weight format that the PE flag-offset logic consumes.
// - Takes a dense stream of channel values, one per cycle, in order ch0..ch(DATA_WIDTH-1).
// - Emits two outputs per group of DATA_WIDTH channels:
//   - a flag word, MSB = ch0, LSB = ch(DATA_WIDTH-1), bit = 1 for a nonzero channel;
//   - the compacted stream of nonzero values, in channel order.
// - Sits between the PE output/activation path and the sparse buffer writer.

---
 rtl/sparse_flag_encoder_pkg.sv | 16 +
 rtl/sparse_skid_reg.sv | 34 +++
 rtl/sparse_flag_encoder.sv | 132 +++++++++++++
 tb/tb_sparse_flag_encoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_flag_encoder_pkg.sv
// Shared constants, log helper and FSM encoding for the sparse flag encoder.
package sparse_flag_encoder_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_VAL_WIDTH  = 8;

    function automatic int C_LOG_2(input int n);
        return $clog2(n);
    endfunction

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } enc_state_t;

endpackage

// File: rtl/sparse_skid_reg.sv
// One-entry valid/ready output register; a load always wins over a same-cycle drain.
module sparse_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_rdy,
    output logic [WIDTH-1:0] o_data,
    output logic             o_val
);

    logic [WIDTH-1:0] r_data;
    logic             r_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_val  <= 1'b0;
        end else begin
            if (i_load) begin
                r_data <= i_data;
                r_val  <= 1'b1;
            end else if (i_rdy) begin
                r_val  <= 1'b0;
            end
        end
    end

    assign o_data = r_data;
    assign o_val  = r_val;

endmodule

// File: rtl/sparse_flag_encoder.sv
// Dense-to-sparse encoder: builds a per-group nonzero flag word and a compacted
// stream of nonzero channel values, ch0 first.
module sparse_flag_encoder
    import sparse_flag_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int VAL_WIDTH  = DEF_VAL_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           I_Sta,
    input  logic                           I_Val,
    input  logic [VAL_WIDTH-1:0]           I_Data,
    output logic                           O_Rdy,
    output logic [VAL_WIDTH-1:0]           O_Dat,
    output logic                           O_Dat_Val,
    input  logic                           I_Dat_Rdy,
    output logic [DATA_WIDTH-1:0]          O_Flag,
    output logic [C_LOG_2(DATA_WIDTH):0]   O_NzCnt,
    output logic                           O_Flag_Val,
    input  logic                           I_Flag_Rdy
);

    localparam int CW = C_LOG_2(DATA_WIDTH);
    localparam int FW = DATA_WIDTH + CW + 1;

    logic [CW-1:0]         r_ch_cnt;
    logic [DATA_WIDTH-1:0] r_flag_acc;
    logic [CW:0]           r_nz_acc;
    enc_state_t            r_state;
    enc_state_t            w_state_next;
    logic                  w_hold;

    logic [CW-1:0]         w_ch;
    logic [DATA_WIDTH-1:0] w_flag_base;
    logic [CW:0]           w_nz_base;
    logic [DATA_WIDTH-1:0] w_flag_next;
    logic [CW:0]           w_nz_next;
    logic                  w_nz;
    logic                  w_last;
    logic                  w_accept;
    logic                  w_flag_stall;
    logic [FW-1:0]         w_flag_pkt;
    logic [FW-1:0]         w_flag_out;

    // I_Sta clears the group in the same cycle, so a coincident beat lands as ch0.
    assign w_ch        = I_Sta ? '0 : r_ch_cnt;
    assign w_flag_base = I_Sta ? '0 : r_flag_acc;
    assign w_nz_base   = I_Sta ? '0 : r_nz_acc;
    assign w_nz        = (I_Data != '0);
    assign w_last      = (w_ch == CW'(DATA_WIDTH - 1));
    assign w_nz_next   = w_nz_base + {{CW{1'b0}}, w_nz};

    // Channel k maps to bit DATA_WIDTH-1-k, which is simply ~k at this width.
    always_comb begin
        w_flag_next        = w_flag_base;
        w_flag_next[~w_ch] = w_nz;
    end

    assign w_flag_stall = w_last && O_Flag_Val && !I_Flag_Rdy;
    assign O_Rdy        = !rst && !w_hold && (!O_Dat_Val || I_Dat_Rdy) && !w_flag_stall;
    assign w_accept     = I_Val && O_Rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch_cnt   <= '0;
            r_flag_acc <= '0;
            r_nz_acc   <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_ch_cnt   <= '0;
                r_flag_acc <= '0;
                r_nz_acc   <= '0;
            end else begin
                r_ch_cnt   <= w_ch + 1'b1;
                r_flag_acc <= w_flag_next;
                r_nz_acc   <= w_nz_next;
            end
        end else if (I_Sta) begin
            r_ch_cnt   <= '0;
            r_flag_acc <= '0;
            r_nz_acc   <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_COLLECT;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_COLLECT: if (w_accept && w_last && O_Flag_Val && !I_Flag_Rdy) w_state_next = ST_HOLD;
            ST_HOLD:    if (I_Flag_Rdy) w_state_next = ST_COLLECT;
            default:    w_state_next = ST_COLLECT;
        endcase
    end

    always_comb begin
        w_hold = (r_state == ST_HOLD);
    end

    // The ready gating makes HOLD unreachable; this guards that invariant.
    a_no_hold: assert property (@(posedge clk) disable iff (rst) r_state == ST_COLLECT);

    sparse_skid_reg #(.WIDTH(VAL_WIDTH)) u_dat_reg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept && w_nz),
        .i_data (I_Data),
        .i_rdy  (I_Dat_Rdy),
        .o_data (O_Dat),
        .o_val  (O_Dat_Val)
    );

    assign w_flag_pkt = {w_flag_next, w_nz_next};

    sparse_skid_reg #(.WIDTH(FW)) u_flag_reg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept && w_last),
        .i_data (w_flag_pkt),
        .i_rdy  (I_Flag_Rdy),
        .o_data (w_flag_out),
        .o_val  (O_Flag_Val)
    );

    assign O_Flag  = w_flag_out[FW-1:CW+1];
    assign O_NzCnt = w_flag_out[CW:0];

endmodule

// File: tb/tb_sparse_flag_encoder.sv
// Directed bench for sparse_flag_encoder: hand-computed flag words, counts and value streams.
module tb_sparse_flag_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        I_Sta = 1'b0;
    logic        I_Val = 1'b0;
    logic [7:0]  I_Data = 8'h00;
    logic        O_Rdy;
    logic [7:0]  O_Dat;
    logic        O_Dat_Val;
    logic        I_Dat_Rdy = 1'b1;
    logic [31:0] O_Flag;
    logic [5:0]  O_NzCnt;
    logic        O_Flag_Val;
    logic        I_Flag_Rdy = 1'b1;

    int checks = 0;
    int errors = 0;
    bit tog = 1'b0;

    logic [7:0]  dq[$];
    logic [31:0] fq[$];
    logic [5:0]  nq[$];
    logic [7:0]  edq[$];
    logic [31:0] efq[$];
    logic [5:0]  enq[$];

    sparse_flag_encoder #(.DATA_WIDTH(32), .VAL_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .I_Sta      (I_Sta),
        .I_Val      (I_Val),
        .I_Data     (I_Data),
        .O_Rdy      (O_Rdy),
        .O_Dat      (O_Dat),
        .O_Dat_Val  (O_Dat_Val),
        .I_Dat_Rdy  (I_Dat_Rdy),
        .O_Flag     (O_Flag),
        .O_NzCnt    (O_NzCnt),
        .O_Flag_Val (O_Flag_Val),
        .I_Flag_Rdy (I_Flag_Rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshakes complete on the next posedge; inputs are stable from posedge+1.
    always @(negedge clk) begin
        if (!rst) begin
            if (O_Dat_Val && I_Dat_Rdy) dq.push_back(O_Dat);
            if (O_Flag_Val && I_Flag_Rdy) begin
                fq.push_back(O_Flag);
                nq.push_back(O_NzCnt);
            end
            if (tog && I_Flag_Rdy) chk("t3_rdy_slot", O_Rdy, (!O_Dat_Val || I_Dat_Rdy));
        end
    end

    always @(posedge clk) begin
        #1;
        if (tog) I_Dat_Rdy = ~I_Dat_Rdy;
    end

    task automatic send(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        I_Val  = 1'b1;
        I_Data = d;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (O_Rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("rdy_timeout", 0, 1);
        @(posedge clk);
        #1;
        I_Val  = 1'b0;
        I_Data = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic compare_all(input string t);
        chk({t, "_ndat"}, dq.size(), edq.size());
        for (int i = 0; i < edq.size(); i++)
            if (i < dq.size()) chk($sformatf("%s_dat%0d", t, i), dq[i], edq[i]);
        chk({t, "_nflag"}, fq.size(), efq.size());
        for (int i = 0; i < efq.size(); i++)
            if (i < fq.size()) begin
                chk($sformatf("%s_flag%0d", t, i), fq[i], efq[i]);
                chk($sformatf("%s_cnt%0d", t, i), nq[i], enq[i]);
            end
        dq.delete(); fq.delete(); nq.delete();
        edq.delete(); efq.delete(); enq.delete();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", O_Rdy, 0);
        chk("rst_dat_val", O_Dat_Val, 0);
        chk("rst_flag_val", O_Flag_Val, 0);
        chk("rst_flag", O_Flag, 0);
        chk("rst_cnt", O_NzCnt, 0);
        chk("rst_dat", O_Dat, 0);
        rst = 1'b0;
        idle(1);
        chk("rdy_after_rst", O_Rdy, 1);

        // All-zero group, flag valid exactly one cycle after beat 31
        for (int i = 0; i < 31; i++) send(8'h00);
        chk("t1_fval_early", O_Flag_Val, 0);
        send(8'h00);
        chk("t1_fval_lat", O_Flag_Val, 1);
        chk("t1_flag_now", O_Flag, 32'h0);
        idle(3);
        efq.push_back(32'h0); enq.push_back(6'd0);
        compare_all("t1");

        // Only ch0 and ch31 nonzero
        for (int i = 0; i < 32; i++)
            send(i == 0 ? 8'h05 : (i == 31 ? 8'h07 : 8'h00));
        idle(3);
        edq.push_back(8'h05); edq.push_back(8'h07);
        efq.push_back(32'h8000_0001); enq.push_back(6'd2);
        compare_all("t2");

        // All nonzero 1..32 with the data sink toggling
        tog = 1'b1;
        for (int i = 1; i <= 32; i++) send(8'(i));
        idle(4);
        tog = 1'b0;
        I_Dat_Rdy = 1'b1;
        idle(3);
        for (int i = 1; i <= 32; i++) edq.push_back(8'(i));
        efq.push_back(32'hFFFF_FFFF); enq.push_back(6'd32);
        compare_all("t3");

        // Flag sink stalled across two back-to-back groups
        I_Flag_Rdy = 1'b0;
        for (int i = 0; i < 32; i++) send(i == 0 ? 8'h11 : 8'h00);
        for (int i = 0; i < 31; i++) send(8'h00);
        chk("t4_hold_flag", O_Flag, 32'h8000_0000);
        chk("t4_hold_cnt", O_NzCnt, 1);
        chk("t4_hold_val", O_Flag_Val, 1);
        I_Val  = 1'b1;
        I_Data = 8'h22;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t4_stall_rdy%0d", k), O_Rdy, 0);
            chk($sformatf("t4_stall_flag%0d", k), O_Flag, 32'h8000_0000);
        end
        @(posedge clk);
        #1;
        I_Flag_Rdy = 1'b1;
        @(negedge clk);
        chk("t4_release_rdy", O_Rdy, 1);
        @(posedge clk);
        #1;
        I_Val  = 1'b0;
        I_Data = 8'h00;
        chk("t4_g2_flag", O_Flag, 32'h0000_0001);
        chk("t4_g2_cnt", O_NzCnt, 1);
        chk("t4_g2_val", O_Flag_Val, 1);
        idle(3);
        edq.push_back(8'h11); edq.push_back(8'h22);
        efq.push_back(32'h8000_0000); enq.push_back(6'd1);
        efq.push_back(32'h0000_0001); enq.push_back(6'd1);
        compare_all("t4");

        // Abort a partial group with I_Sta
        for (int i = 0; i < 10; i++) send(i == 2 ? 8'h33 : 8'h00);
        I_Sta = 1'b1;
        @(posedge clk);
        #1;
        I_Sta = 1'b0;
        for (int i = 0; i < 32; i++) send(8'h00);
        idle(3);
        edq.push_back(8'h33);
        efq.push_back(32'h0); enq.push_back(6'd0);
        compare_all("t5");

        // Asynchronous reset in the middle of a group
        for (int i = 0; i < 16; i++) send(8'h00);
        I_Dat_Rdy = 1'b0;
        send(8'h44);
        chk("t6_dat_val", O_Dat_Val, 1);
        chk("t6_dat", O_Dat, 8'h44);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_dat_val", O_Dat_Val, 0);
        chk("t6_rst_dat", O_Dat, 0);
        chk("t6_rst_rdy", O_Rdy, 0);
        chk("t6_rst_fval", O_Flag_Val, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        I_Dat_Rdy = 1'b1;
        dq.delete(); fq.delete(); nq.delete();
        for (int i = 0; i < 32; i++)
            send(i == 0 ? 8'h01 : (i == 5 ? 8'h06 : 8'h00));
        idle(3);
        edq.push_back(8'h01); edq.push_back(8'h06);
        efq.push_back(32'h8400_0000); enq.push_back(6'd2);
        compare_all("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
